// File: rtl/uart_pkg.sv
// Shared UART constants, derived bit timing and capture FSM encoding.
// Used by the receiver and by the receive buffer controller.
package uart_pkg;
    localparam int CLK_FREQUENCY     = 50_000_000;
    localparam int BAUD_RATE         = 115_200;
    localparam int CLKS_PER_BIT      = CLK_FREQUENCY / BAUD_RATE;
    localparam int CLKS_PER_HALF_BIT = CLKS_PER_BIT / 2;
    localparam int DATA_BITS         = 8;
    localparam int FRAME_BITS        = DATA_BITS + 2;

    typedef logic [DATA_BITS-1:0] byte_t;

    typedef enum logic [1:0] {
        CAP_WAIT = 2'd0,
        CAP_ACK  = 2'd1,
        CAP_HOLD = 2'd2
    } cap_state_t;
endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO, first-word-fall-through head; a push lands on head_data one cycle later.
// Push while full is accepted only together with a pop; pop while empty is ignored.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  byte_t           push_data,
    input  logic            pop,
    output byte_t           head_data,
    output logic [ADDR_W:0] count,
    output logic            full
);
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

    byte_t             mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              empty;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage is never reset, so mask the head while empty to keep it defined.
    assign head_data = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/uart_rx_buffer_ctrl.sv
// Captures receiver bytes into a FIFO with a one-cycle read_complete handshake.
// Byte visible on out_data the cycle after capture; full FIFO drops and flags sticky overflow.
module uart_rx_buffer_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      rx_data,
    input  logic            rx_valid,
    output logic            rx_read_complete,
    output logic [7:0]      out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ADDR_W:0] count,
    output logic            overflow,
    input  logic            overflow_clear
);
    cap_state_t state;
    cap_state_t state_nxt;
    logic       capture;
    logic       pop;
    logic       fifo_full;
    logic       space;
    logic       push;
    logic       drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CAP_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    // HOLD waits for the receiver to drop its flag so one byte is never taken twice.
    always_comb begin
        state_nxt = state;
        case (state)
            CAP_WAIT: if (rx_valid) state_nxt = CAP_ACK;
            CAP_ACK:  state_nxt = CAP_HOLD;
            CAP_HOLD: if (!rx_valid) state_nxt = CAP_WAIT;
            default:  state_nxt = CAP_WAIT;
        endcase
    end

    always_comb begin
        rx_read_complete = 1'b0;
        capture          = 1'b0;
        case (state)
            CAP_WAIT: capture = rx_valid;
            CAP_ACK:  rx_read_complete = 1'b1;
            default:  ;
        endcase
    end

    assign pop   = out_valid && out_ready;
    assign space = !fifo_full || pop;
    assign push  = capture && space;
    assign drop  = capture && !space;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clear) begin
            overflow <= 1'b0;
        end
    end

    uart_byte_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (rx_data),
        .pop       (pop),
        .head_data (out_data),
        .count     (count),
        .full      (fifo_full)
    );

    assign out_valid = (count != '0);
endmodule

// File: doc/uart_rx_buffer_ctrl.md
UART_RX_BUFFER_CTRL -- requirements
Module: uart_rx_buffer_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 2..256).
REQ-002 SHALL have parameter ADDR_W, default 3, pointer width (log2 DEPTH).
REQ-003 SHALL have port clk  input  1  system clock (50 MHz).
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx_data  input  8  byte from UART receiver data_out.
REQ-006 SHALL have port rx_valid  input  1  receiver RC flag; rx_data valid while high.
REQ-007 SHALL have port rx_read_complete  output  1  one-cycle acknowledge to receiver read_complete.
REQ-008 SHALL have port out_data  output  8  head-of-FIFO byte.
REQ-009 SHALL have port out_valid  output  1  out_data valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts head byte.
REQ-011 SHALL have port count  output  ADDR_W+1  bytes currently stored.
REQ-012 SHALL have port overflow  output  1  sticky: byte dropped because FIFO full.
REQ-013 SHALL have port overflow_clear  input  1  clears overflow.

Function
REQ-014 Capture FSM SHALL have states WAIT, ACK, HOLD.
REQ-015 WAIT: rx_valid=1 -> write rx_data at that edge (if space), register rx_read_complete<=1, go ACK; else stay.
REQ-016 ACK: rx_read_complete<=0, go HOLD (receiver clears RC at end of ACK cycle).
REQ-017 HOLD: rx_valid=0 -> WAIT; else stay, no capture, no timeout.
REQ-018 rx_read_complete SHALL be high exactly one cycle per captured or dropped byte, never two consecutive cycles.
REQ-019 Space SHALL exist when count<DEPTH, or count==DEPTH with pop in same cycle (count unchanged, both pointers advance).
REQ-020 No space: byte discarded, still acknowledged, overflow<=1.
REQ-021 overflow set and overflow_clear in same cycle: set wins.
REQ-022 Output SHALL be first-word-fall-through: out_valid = (count!=0), out_data = head entry, out_data=8'h00 when count==0.
REQ-023 Pop occurs on edge with out_valid && out_ready; out_ready while empty SHALL be ignored.
REQ-024 Latency: byte sampled at WAIT edge SHALL appear on out_data/out_valid in the next cycle.
REQ-025 Simultaneous push and pop with 0<count<DEPTH: count unchanged.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH; count range 0..DEPTH, never exceeding DEPTH.
REQ-027 Byte order out SHALL equal capture order.

Reset
REQ-028 reset SHALL asynchronously force: state WAIT, pointers 0, count 0, overflow 0, rx_read_complete 0, out_valid 0, out_data 8'h00.
REQ-029 FIFO storage SHALL not require reset.
REQ-030 Reset mid-operation: stored bytes lost; if rx_valid still high after release, that byte SHALL be captured once in WAIT.

Structure
REQ-031 Shared package/header uart_pkg SHALL hold clk_frequency, baud_rate, derived bit counts and FSM state encodings, shared with the receiver.
REQ-032 Storage, pointers and count SHALL reside in sub-module uart_byte_fifo; FSM and overflow logic in the top.

Verification
REQ-033 Single byte: rx_valid high with rx_data=8'hA5, receiver model clears RC after ack -> one rx_read_complete pulse, out_data=8'hA5, out_valid next cycle, count=1.
REQ-034 Fill: 8 bytes 8'h01..8'h08, out_ready=0 -> count=8, overflow=0; 9th byte 8'hFF -> acknowledged, dropped, overflow=1, count=8.
REQ-035 Full plus pop: count=8, out_ready=1 in capture cycle of 8'h09 -> 8'h09 accepted, count stays 8, readout order 8'h02..8'h09.
REQ-036 Overflow priority: overflow_clear=1 same cycle as a drop -> overflow remains 1; clear next cycle -> overflow=0.
REQ-037 Stuck RC: rx_valid held high 20 cycles -> exactly one capture and one rx_read_complete pulse.
REQ-038 Reset mid-stream: count=5, assert reset asynchronously -> all outputs at reset values immediately; 8'h3C after release -> out_data=8'h3C, count=1.
